cmd_arb: RTL and testbench

Command arbiter/scheduler in front of `cmd_proc`. It queues 16-bit host commands arriving from the UART wrapper and accepts move commands from the tour logic. It issues one command at a time to `cmd_proc` through the `cmd_rdy`/`clr_cmd_rdy` handshake and waits for `send_resp` before issuing the next. Until calibration completes, it blocks every command other than calibrate.

---
 rtl/cmd_arb_pkg.sv | 25 ++
 rtl/cmd_fifo.sv | 45 ++++
 rtl/cmd_arb.sv | 178 +++++++++++++++++
 tb/tb_cmd_arb.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_arb_pkg.sv
// Shared opcodes, response bytes and state/source encodings for the command arbiter.
package cmd_arb_pkg;

  localparam logic [3:0] OP_CAL   = 4'h2;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_REJ = 8'hE1;
  localparam logic [7:0] RESP_TMO = 8'hEE;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef enum logic {
    HOST,
    TOUR
  } src_t;

  function automatic logic is_cal_cmd(input logic [15:0] word);
    return word[15:12] == OP_CAL;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Host command FIFO: power-of-2 depth, wrap-around pointers with an extra lap bit.
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = wr_ptr_q == rd_ptr_q;
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the head slot this cycle, so a push while full is still accepted.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cmd_arb.sv
// Arbitrates queued host commands and tour moves into cmd_proc, one at a time.
// Optional response watchdog enabled by defining CMD_ARB_TIMEOUT_EN.
module cmd_arb
  import cmd_arb_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1 << 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] host_cmd,
  input  logic        host_vld,
  output logic        host_full,
  output logic        host_ovf,
  output logic [7:0]  host_resp,
  output logic        host_resp_vld,
  input  logic [15:0] tour_cmd,
  input  logic        tour_req,
  output logic        tour_gnt,
  output logic        tour_done,
  output logic        tour_err,
  input  logic        cal_done,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("cmd_arb: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
  end

  logic [15:0] head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;

  state_t      state_q;
  src_t        src_q;
  src_t        last_src_q;
  logic        cal_ok_q;
  logic [15:0] cmd_q;
  logic        cmd_rdy_q;
  logic [7:0]  host_resp_q;
  logic        host_resp_vld_q;
  logic        host_ovf_q;
  logic        tour_gnt_q;
  logic        tour_done_q;

  logic        host_cand;
  logic        tour_cand;
  logic        sel_host;
  logic        sel_tour;
  logic        reject;
  logic        expire;
  logic        finish;

  cmd_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(16)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (host_vld),
    .din  (host_cmd),
    .pop  (fifo_pop),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    host_cand = !fifo_empty;
    tour_cand = tour_req && cal_ok_q;
    // Round-robin: host wins a tie only if the previous issue went to the tour.
    sel_host  = (state_q == IDLE) && host_cand && (!tour_cand || last_src_q == TOUR);
    sel_tour  = (state_q == IDLE) && tour_cand && !sel_host;
    reject    = sel_host && !cal_ok_q && !is_cal_cmd(head);
    fifo_pop  = sel_host;
    finish    = (state_q != IDLE) && (send_resp || expire);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      src_q           <= HOST;
      last_src_q      <= TOUR;
      cal_ok_q        <= 1'b0;
      cmd_q           <= '0;
      cmd_rdy_q       <= 1'b0;
      host_resp_q     <= '0;
      host_resp_vld_q <= 1'b0;
      host_ovf_q      <= 1'b0;
      tour_gnt_q      <= 1'b0;
      tour_done_q     <= 1'b0;
    end else begin
      host_resp_vld_q <= 1'b0;
      tour_gnt_q      <= 1'b0;
      tour_done_q     <= 1'b0;
      if (cal_done) cal_ok_q <= 1'b1;
      if (host_vld && fifo_full && !fifo_pop) host_ovf_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (reject) begin
            host_resp_q     <= RESP_REJ;
            host_resp_vld_q <= 1'b1;
          end else if (sel_host) begin
            cmd_q      <= head;
            cmd_rdy_q  <= 1'b1;
            src_q      <= HOST;
            last_src_q <= HOST;
            state_q    <= ISSUE;
          end else if (sel_tour) begin
            cmd_q      <= tour_cmd;
            cmd_rdy_q  <= 1'b1;
            tour_gnt_q <= 1'b1;
            src_q      <= TOUR;
            last_src_q <= TOUR;
            state_q    <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (finish) begin
            cmd_rdy_q <= 1'b0;
            state_q   <= IDLE;
            if (src_q == HOST) begin
              host_resp_q     <= send_resp ? RESP_ACK : RESP_TMO;
              host_resp_vld_q <= 1'b1;
            end else begin
              tour_done_q <= 1'b1;
            end
          end else if (state_q == ISSUE && clr_cmd_rdy) begin
            cmd_rdy_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CMD_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt_q;
  logic          tour_err_q;

  // Counter sits at zero while idle, so it starts from zero on entry to ISSUE.
  assign expire = (state_q != IDLE) && !send_resp && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q  <= '0;
      tour_err_q <= 1'b0;
    end else begin
      tour_err_q <= expire && (src_q == TOUR);
      if (state_q == IDLE) tmo_cnt_q <= '0;
      else                 tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign tour_err = tour_err_q;
`else
  assign expire   = 1'b0;
  assign tour_err = 1'b0;
`endif

  assign host_full     = fifo_full;
  assign host_ovf      = host_ovf_q;
  assign host_resp     = host_resp_q;
  assign host_resp_vld = host_resp_vld_q;
  assign tour_gnt      = tour_gnt_q;
  assign tour_done     = tour_done_q;
  assign cmd           = cmd_q;
  assign cmd_rdy       = cmd_rdy_q;

endmodule

// File: tb/tb_cmd_arb.sv
// Directed bench for cmd_arb; timeout scenarios follow CMD_ARB_TIMEOUT_EN.
module tb_cmd_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] host_cmd;
  logic        host_vld;
  logic        host_full;
  logic        host_ovf;
  logic [7:0]  host_resp;
  logic        host_resp_vld;
  logic [15:0] tour_cmd;
  logic        tour_req;
  logic        tour_gnt;
  logic        tour_done;
  logic        tour_err;
  logic        cal_done;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;

  int vectors = 0;
  int miscompares = 0;

  cmd_arb #(
    .DEPTH(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_cmd     (host_cmd),
    .host_vld     (host_vld),
    .host_full    (host_full),
    .host_ovf     (host_ovf),
    .host_resp    (host_resp),
    .host_resp_vld(host_resp_vld),
    .tour_cmd     (tour_cmd),
    .tour_req     (tour_req),
    .tour_gnt     (tour_gnt),
    .tour_done    (tour_done),
    .tour_err     (tour_err),
    .cal_done     (cal_done),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp)
  );

  always #5 clk = ~clk;

  // Advance one cycle, sample 1 ns after the edge, and retire one-cycle pulses.
  task automatic step();
    @(posedge clk);
    #1;
    host_vld    = 1'b0;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    cal_done    = 1'b0;
  endtask

  task automatic push(input logic [15:0] c);
    host_cmd = c;
    host_vld = 1'b1;
    step();
  endtask

  task automatic wait_rdy(output bit ok);
    int n = 0;
    while (cmd_rdy !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    ok = (cmd_rdy === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    vectors++;
    if ({cmd_rdy, host_full, host_ovf, host_resp_vld, tour_gnt, tour_done, tour_err} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000000",
               {cmd_rdy, host_full, host_ovf, host_resp_vld, tour_gnt, tour_done, tour_err});
    end
    vectors++;
    if (cmd !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_cmd: got %h want 0000", cmd);
    end
    vectors++;
    if (host_resp !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_resp: got %h want 00", host_resp);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_cal_cmd();
    push(16'h2000);
    vectors++;
    if (cmd_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL cal_cmd_early: cmd_rdy=%b want 0 one cycle after push", cmd_rdy);
    end
    step();
    vectors++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h2000) begin
      miscompares++;
      $display("FAIL cal_cmd_issue: cmd_rdy=%b cmd=%h want 1 2000", cmd_rdy, cmd);
    end
    clr_cmd_rdy = 1'b1;
    step();
    vectors++;
    if (cmd_rdy !== 1'b0 || host_resp_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL cal_cmd_clr: cmd_rdy=%b resp_vld=%b want 0 0", cmd_rdy, host_resp_vld);
    end
    send_resp = 1'b1;
    step();
    vectors++;
    if (host_resp_vld !== 1'b1 || host_resp !== 8'hA5) begin
      miscompares++;
      $display("FAIL cal_cmd_ack: vld=%b resp=%h want 1 a5", host_resp_vld, host_resp);
    end
    step();
    vectors++;
    if (host_resp_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL cal_cmd_pulse: vld=%b want 0", host_resp_vld);
    end
  endtask

  task automatic test_reject();
    int   n_resp = 0;
    bit   rdy_seen = 0;
    bit   gnt_seen = 0;
    logic [7:0] resp_val = 8'h00;
    tour_cmd = 16'h3000;
    tour_req = 1'b1;
    push(16'h4001);
    for (int i = 0; i < 8; i++) begin
      if (host_resp_vld === 1'b1) begin
        n_resp++;
        resp_val = host_resp;
      end
      if (cmd_rdy === 1'b1) rdy_seen = 1;
      if (tour_gnt === 1'b1) gnt_seen = 1;
      step();
    end
    tour_req = 1'b0;
    vectors++;
    if (n_resp != 1 || resp_val !== 8'hE1) begin
      miscompares++;
      $display("FAIL reject_resp: count=%0d resp=%h want 1 e1", n_resp, resp_val);
    end
    vectors++;
    if (rdy_seen || gnt_seen) begin
      miscompares++;
      $display("FAIL reject_block: rdy_seen=%b gnt_seen=%b want 0 0", rdy_seen, gnt_seen);
    end
  endtask

  task automatic test_tour_latency();
    cal_done = 1'b1;
    step();
    tour_cmd = 16'h3001;
    tour_req = 1'b1;
    step();
    vectors++;
    if (tour_gnt !== 1'b1 || cmd_rdy !== 1'b1 || cmd !== 16'h3001) begin
      miscompares++;
      $display("FAIL tour_issue: gnt=%b rdy=%b cmd=%h want 1 1 3001", tour_gnt, cmd_rdy, cmd);
    end
    tour_req = 1'b0;
    tour_cmd = 16'h0000;
    step();
    vectors++;
    if (tour_gnt !== 1'b0 || cmd_rdy !== 1'b1 || cmd !== 16'h3001) begin
      miscompares++;
      $display("FAIL tour_hold: gnt=%b rdy=%b cmd=%h want 0 1 3001", tour_gnt, cmd_rdy, cmd);
    end
    clr_cmd_rdy = 1'b1;
    step();
    send_resp = 1'b1;
    step();
    vectors++;
    if (tour_done !== 1'b1 || host_resp_vld !== 1'b0 || tour_err !== 1'b0) begin
      miscompares++;
      $display("FAIL tour_done: done=%b resp_vld=%b err=%b want 1 0 0",
               tour_done, host_resp_vld, tour_err);
    end
    step();
    vectors++;
    if (tour_done !== 1'b0) begin
      miscompares++;
      $display("FAIL tour_done_pulse: done=%b want 0", tour_done);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_cmd [5] = '{16'h1001, 16'h3101, 16'h1002, 16'h3102, 16'h1003};
    bit          exp_tour[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit ok;
    push(16'h1001);
    tour_cmd = 16'h3101;
    tour_req = 1'b1;
    push(16'h1002);
    push(16'h1003);
    for (int i = 0; i < 5; i++) begin
      wait_rdy(ok);
      vectors++;
      if (!ok || cmd !== exp_cmd[i] || tour_gnt !== exp_tour[i]) begin
        miscompares++;
        $display("FAIL rr_issue%0d: rdy=%b cmd=%h gnt=%b want 1 %h %b",
                 i, ok, cmd, tour_gnt, exp_cmd[i], exp_tour[i]);
      end
      if (exp_tour[i]) begin
        if (i == 1) tour_cmd = 16'h3102;
        else        tour_req = 1'b0;
      end
      clr_cmd_rdy = 1'b1;
      step();
      send_resp = 1'b1;
      step();
      vectors++;
      if (exp_tour[i] ? (tour_done !== 1'b1 || host_resp_vld !== 1'b0)
                      : (host_resp_vld !== 1'b1 || host_resp !== 8'hA5 || tour_done !== 1'b0)) begin
        miscompares++;
        $display("FAIL rr_done%0d: done=%b resp_vld=%b resp=%h tour=%b",
                 i, tour_done, host_resp_vld, host_resp, exp_tour[i]);
      end
    end
    tour_req = 1'b0;
  endtask

  task automatic test_overflow();
    bit ok;
    bit rdy_seen = 0;
    push(16'h5000);
    wait_rdy(ok);
    for (int k = 0; k < 4; k++) push(16'h6001 + 16'(k));
    vectors++;
    if (!ok || host_full !== 1'b1 || host_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_fill: busy=%b full=%b ovf=%b want 1 1 0", ok, host_full, host_ovf);
    end
    push(16'h6005);
    vectors++;
    if (host_full !== 1'b1 || host_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_drop: full=%b ovf=%b want 1 1", host_full, host_ovf);
    end
    clr_cmd_rdy = 1'b1;
    step();
    send_resp = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      wait_rdy(ok);
      vectors++;
      if (!ok || cmd !== 16'h6001 + 16'(i)) begin
        miscompares++;
        $display("FAIL ovf_order%0d: rdy=%b cmd=%h want 1 %h", i, ok, cmd, 16'h6001 + 16'(i));
      end
      clr_cmd_rdy = 1'b1;
      step();
      send_resp = 1'b1;
      step();
    end
    for (int i = 0; i < 10; i++) begin
      if (cmd_rdy === 1'b1) rdy_seen = 1;
      step();
    end
    vectors++;
    if (rdy_seen || host_full !== 1'b0 || host_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_tail: extra_issue=%b full=%b ovf=%b want 0 0 1",
               rdy_seen, host_full, host_ovf);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
`ifdef CMD_ARB_TIMEOUT_EN
    push(16'h8001);
    wait_rdy(ok);
    n = 0;
    while (host_resp_vld !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    vectors++;
    if (!ok || n != 16 || host_resp !== 8'hEE || cmd_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_host: cycles=%0d resp=%h rdy=%b want 16 ee 0", n, host_resp, cmd_rdy);
    end
    tour_cmd = 16'h3201;
    tour_req = 1'b1;
    step();
    tour_req = 1'b0;
    n = 0;
    while (tour_done !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    vectors++;
    if (n != 16 || tour_err !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_tour: cycles=%0d err=%b want 16 1", n, tour_err);
    end
    step();
    vectors++;
    if (tour_err !== 1'b0 || tour_done !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_tour_pulse: err=%b done=%b want 0 0", tour_err, tour_done);
    end
    push(16'h8002);
    wait_rdy(ok);
    for (int i = 0; i < 15; i++) step();
    send_resp = 1'b1;
    step();
    vectors++;
    if (!ok || host_resp_vld !== 1'b1 || host_resp !== 8'hA5) begin
      miscompares++;
      $display("FAIL tmo_race: vld=%b resp=%h want 1 a5", host_resp_vld, host_resp);
    end
`else
    bit resp_seen = 0;
    push(16'h8001);
    wait_rdy(ok);
    for (int i = 0; i < 40; i++) begin
      if (host_resp_vld === 1'b1 || tour_err !== 1'b0) resp_seen = 1;
      step();
    end
    vectors++;
    if (!ok || cmd_rdy !== 1'b1 || resp_seen) begin
      miscompares++;
      $display("FAIL no_tmo_hold: rdy=%b early_resp=%b want 1 0", cmd_rdy, resp_seen);
    end
    n = 0;
    send_resp = 1'b1;
    step();
    vectors++;
    if (host_resp_vld !== 1'b1 || host_resp !== 8'hA5 || n != 0) begin
      miscompares++;
      $display("FAIL no_tmo_ack: vld=%b resp=%h want 1 a5", host_resp_vld, host_resp);
    end
`endif
  endtask

  task automatic test_same_cycle();
    bit ok;
    push(16'h7001);
    wait_rdy(ok);
    clr_cmd_rdy = 1'b1;
    send_resp   = 1'b1;
    step();
    vectors++;
    if (!ok || host_resp_vld !== 1'b1 || host_resp !== 8'hA5 || cmd_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL same_cycle_done: vld=%b resp=%h rdy=%b want 1 a5 0",
               host_resp_vld, host_resp, cmd_rdy);
    end
    send_resp   = 1'b1;
    clr_cmd_rdy = 1'b1;
    step();
    vectors++;
    if (host_resp_vld !== 1'b0 || tour_done !== 1'b0 || cmd_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ignore: vld=%b done=%b rdy=%b want 0 0 0",
               host_resp_vld, tour_done, cmd_rdy);
    end
    push(16'h7002);
    step();
    vectors++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h7002) begin
      miscompares++;
      $display("FAIL same_cycle_next: rdy=%b cmd=%h want 1 7002", cmd_rdy, cmd);
    end
  endtask

  task automatic test_reset_in_wait();
    int   n_resp = 0;
    logic [7:0] resp_val = 8'h00;
    clr_cmd_rdy = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    vectors++;
    if ({cmd_rdy, host_full, host_ovf, host_resp_vld, tour_gnt, tour_done, tour_err} !== 7'b0 ||
        cmd !== 16'h0 || host_resp !== 8'h0) begin
      miscompares++;
      $display("FAIL wait_reset: flags=%b cmd=%h resp=%h want 0000000 0000 00",
               {cmd_rdy, host_full, host_ovf, host_resp_vld, tour_gnt, tour_done, tour_err},
               cmd, host_resp);
    end
    rst_n = 1'b1;
    step();
    push(16'h4002);
    for (int i = 0; i < 6; i++) begin
      if (host_resp_vld === 1'b1) begin
        n_resp++;
        resp_val = host_resp;
      end
      step();
    end
    vectors++;
    if (n_resp != 1 || resp_val !== 8'hE1) begin
      miscompares++;
      $display("FAIL cal_cleared: count=%0d resp=%h want 1 e1", n_resp, resp_val);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    host_cmd    = '0;
    host_vld    = 1'b0;
    tour_cmd    = '0;
    tour_req    = 1'b0;
    cal_done    = 1'b0;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    test_reset();
    test_cal_cmd();
    test_reject();
    test_tour_latency();
    test_round_robin();
    test_overflow();
    test_timeout();
    test_same_cycle();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
